proc_run_monitor: RTL and testbench

Run-control monitor sitting directly downstream of the processor core in the processor-level bench hierarchy. It consumes the core's `err`, `halt` and instruction-retire strobes, counts cycles and retired instructions, and classifies how the run ended: pass, error or watchdog timeout. After a programmable drain period it raises a sticky stop request that the clock/reset generator uses to end simulation.

---
 rtl/proc_run_monitor.sv | 153 +++++++++++++++
 tb/tb_proc_run_monitor.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/proc_run_monitor.sv
// Run-control monitor: counts cycles/retires, classifies run end (pass/error/timeout), raises sticky stop_req after a drain period.
// Optional watchdog timeout enabled by defining PROC_RUN_MONITOR_WATCHDOG_EN.
module proc_run_monitor #(
  parameter int CNT_W     = 32,
  parameter int TIMEOUT   = 100000,
  parameter int DRAIN_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             err,
  input  logic             halt,
  input  logic             retire,
  output logic             stop_req,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] event_cycle
);

  localparam int DW = $clog2(DRAIN_CYC + 2);
  localparam logic [DW-1:0] DRAIN_LAST = (DRAIN_CYC > 0) ? DW'(DRAIN_CYC - 1) : {DW{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_DRAIN   = 2'b01,
    ST_STOPPED = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cycle_cnt, w_cycle_nxt;
  logic [CNT_W-1:0] r_instr_cnt, w_instr_nxt;
  logic [CNT_W-1:0] r_event_cycle, w_event_nxt;
  logic [1:0]       r_status, w_status_nxt;
  logic             r_stop_req, w_stop_nxt;
  logic [DW-1:0]    r_drain_cnt, w_drain_nxt;
  logic             w_timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

`ifdef PROC_RUN_MONITOR_WATCHDOG_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT);

  logic [IW-1:0] r_idle_cnt;

  // Consecutive non-retire edges in RUN; frozen elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= {IW{1'b0}};
    end else if (r_state == ST_RUN) begin
      if (retire) begin
        r_idle_cnt <= {IW{1'b0}};
      end else if (r_idle_cnt != IDLE_MAX) begin
        r_idle_cnt <= r_idle_cnt + IW'(1);
      end else begin
        r_idle_cnt <= r_idle_cnt;
      end
    end else begin
      r_idle_cnt <= r_idle_cnt;
    end
  end

  assign w_timeout = (r_state == ST_RUN) && !retire && (r_idle_cnt == IDLE_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state and next-value logic for all run-control registers.
  always_comb begin
    w_state_nxt  = r_state;
    w_cycle_nxt  = r_cycle_cnt;
    w_instr_nxt  = r_instr_cnt;
    w_event_nxt  = r_event_cycle;
    w_status_nxt = r_status;
    w_drain_nxt  = r_drain_cnt;
    case (r_state)
      ST_RUN: begin
        w_cycle_nxt = sat_inc(r_cycle_cnt);
        if (retire) begin
          w_instr_nxt = sat_inc(r_instr_cnt);
        end else begin
          w_instr_nxt = r_instr_cnt;
        end
        if (err || w_timeout || halt) begin
          w_event_nxt = r_cycle_cnt;
          w_drain_nxt = {DW{1'b0}};
          if (err) begin
            w_status_nxt = 2'b10;
          end else if (w_timeout) begin
            w_status_nxt = 2'b11;
          end else begin
            w_status_nxt = 2'b01;
          end
          if (DRAIN_CYC == 0) begin
            w_state_nxt = ST_STOPPED;
          end else begin
            w_state_nxt = ST_DRAIN;
          end
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        w_cycle_nxt = sat_inc(r_cycle_cnt);
        if (r_drain_cnt == DRAIN_LAST) begin
          w_state_nxt = ST_STOPPED;
        end else begin
          w_drain_nxt = r_drain_cnt + DW'(1);
        end
      end
      ST_STOPPED: begin
        w_state_nxt = ST_STOPPED;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
    w_stop_nxt = (w_state_nxt == ST_STOPPED);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_cycle_cnt   <= {CNT_W{1'b0}};
      r_instr_cnt   <= {CNT_W{1'b0}};
      r_event_cycle <= {CNT_W{1'b0}};
      r_status      <= 2'b00;
      r_stop_req    <= 1'b0;
      r_drain_cnt   <= {DW{1'b0}};
    end else begin
      r_state       <= w_state_nxt;
      r_cycle_cnt   <= w_cycle_nxt;
      r_instr_cnt   <= w_instr_nxt;
      r_event_cycle <= w_event_nxt;
      r_status      <= w_status_nxt;
      r_stop_req    <= w_stop_nxt;
      r_drain_cnt   <= w_drain_nxt;
    end
  end

  assign stop_req    = r_stop_req;
  assign status      = r_status;
  assign cycle_cnt   = r_cycle_cnt;
  assign instr_cnt   = r_instr_cnt;
  assign event_cycle = r_event_cycle;

endmodule

// File: tb/tb_proc_run_monitor.sv
// Randomized self-checking bench for proc_run_monitor: two instances (different widths/drain) vs. a per-edge behavioural model.
module tb_proc_run_monitor;

  localparam int W1 = 6, T1 = 8, D1 = 4;
  localparam int W0 = 4, T0 = 5, D0 = 0;
`ifdef PROC_RUN_MONITOR_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err = 1'b0, halt = 1'b0, retire = 1'b0;

  logic          stop1, stop0;
  logic [1:0]    stat1, stat0;
  logic [W1-1:0] cyc1, ins1, evc1;
  logic [W0-1:0] cyc0, ins0, evc0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int phase;   // 0 running, 1 draining, 2 stopped
    int cyc, ins, idle, left, status, evc, stop;
  } mdl_t;

  mdl_t m1, m0;

  always #5 clk = ~clk;

  proc_run_monitor #(.CNT_W(W1), .TIMEOUT(T1), .DRAIN_CYC(D1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .err(err), .halt(halt), .retire(retire),
    .stop_req(stop1), .status(stat1), .cycle_cnt(cyc1), .instr_cnt(ins1), .event_cycle(evc1));

  proc_run_monitor #(.CNT_W(W0), .TIMEOUT(T0), .DRAIN_CYC(D0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .err(err), .halt(halt), .retire(retire),
    .stop_req(stop0), .status(stat0), .cycle_cnt(cyc0), .instr_cnt(ins0), .event_cycle(evc0));

  task automatic check_value(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic mdl_t model_reset();
    mdl_t m;
    m = '{default: 0};
    return m;
  endfunction

  function automatic mdl_t model_step(mdl_t m, int cmax, int tmo, int dcyc, bit e, bit h, bit r);
    mdl_t n;
    bit   to;
    n = m;
    if (m.phase == 2) return n;
    if (m.cyc < cmax) n.cyc = m.cyc + 1;
    if (m.phase == 0) begin
      if (r && m.ins < cmax) n.ins = m.ins + 1;
      n.idle = r ? 0 : m.idle + 1;
      to = WD_EN && (n.idle >= tmo);
      if (e || to || h) begin
        n.status = e ? 2 : (to ? 3 : 1);
        n.evc    = m.cyc;
        n.left   = dcyc;
        n.phase  = (dcyc == 0) ? 2 : 1;
      end
    end else begin
      n.left = m.left - 1;
      if (n.left == 0) n.phase = 2;
    end
    n.stop = (n.phase == 2) ? 1 : 0;
    return n;
  endfunction

  task automatic check_all(input string tag);
    check_value({tag, ".d1.stop"}, int'(stop1), m1.stop);
    check_value({tag, ".d1.status"}, int'(stat1), m1.status);
    check_value({tag, ".d1.cycle"}, int'(cyc1), m1.cyc);
    check_value({tag, ".d1.instr"}, int'(ins1), m1.ins);
    check_value({tag, ".d1.evc"}, int'(evc1), m1.evc);
    check_value({tag, ".d0.stop"}, int'(stop0), m0.stop);
    check_value({tag, ".d0.status"}, int'(stat0), m0.status);
    check_value({tag, ".d0.cycle"}, int'(cyc0), m0.cyc);
    check_value({tag, ".d0.instr"}, int'(ins0), m0.ins);
    check_value({tag, ".d0.evc"}, int'(evc0), m0.evc);
  endtask

  // Inputs to be sampled at edge k of a run in the given mode.
  task automatic drive(input int mode, input int k);
    case (mode)
      0: begin retire = 1'b1; err = 1'b0; halt = 1'b0; end
      2: begin retire = (k <= 5); err = 1'b0; halt = 1'b0; end
      3: begin retire = 1'b1; err = 1'b0; halt = (k == 20); end
      4: begin retire = $urandom % 2 == 0; err = (k == 10); halt = (k == 10) || (k == 12); end
      5: begin retire = ($urandom % 8) == 0; err = ($urandom % 50) == 0; halt = ($urandom % 60) == 0; end
      default: begin
        retire = ($urandom % 10) < 7;
        err    = ($urandom % 60) == 0;
        halt   = ($urandom % 40) == 0;
      end
    endcase
  endtask

  task automatic run_case(input int mode, input int len);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= len; k++) begin
      drive(mode, k);
      @(posedge clk);
      #1;
      m1 = model_step(m1, (1 << W1) - 1, T1, D1, err, halt, retire);
      m0 = model_step(m0, (1 << W0) - 1, T0, D0, err, halt, retire);
      check_all($sformatf("m%0d.e%0d", mode, k));
    end
    if (mode == 3) begin
      check_value("halt20.status", int'(stat1), 1);
      check_value("halt20.evc", int'(evc1), 19);
      check_value("halt20.instr", int'(ins1), 20);
      check_value("halt20.cycle", int'(cyc1), 24);
      check_value("halt20.stop", int'(stop1), 1);
    end
    if (mode == 4) begin
      check_value("errhalt.status", int'(stat1), 2);
      check_value("errhalt.evc", int'(evc1), 9);
    end
    retire = 1'b0; err = 1'b0; halt = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    m1 = model_reset();
    m0 = model_reset();
    check_all($sformatf("m%0d.rst", mode));
  endtask

  initial begin
    m1 = model_reset();
    m0 = model_reset();
    #2;
    check_all("por");
    run_case(3, 30);
    run_case(4, 14);
    run_case(4, 12);   // reset lands mid-drain
    run_case(2, 20);
    run_case(0, 70);
    for (int i = 0; i < 20; i++) begin
      run_case((i % 3 == 0) ? 5 : 1, $urandom_range(10, 80));
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
